timekeeper_ctrl: RTL and testbench
==================================

TIMEKEEPER_CTRL -- requirements
Module: timekeeper_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- CLK_HZ, 100000000, clk cycles per second; must be at least 4.
- REPEAT_DLY, CLK_HZ/2, cycles a button is held before auto-repeat starts.
- REPEAT_PER, CLK_HZ/10, cycles between auto-repeat pulses.
- MODE_12H, 0, 1 selects 12-hour display with pm flag; 0 selects 24-hour display.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic is clocked on its rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- run  in  1  level; 1 enables timekeeping.
- clr  in  1  debounced level; synchronous clear to midnight.
- hr_btn  in  1  debounced level; hour set button.
- min_btn  in  1  debounced level; minute set button.
- alm_hr  in  5  alarm hour, binary 0-23.
- alm_min  in  6  alarm minute, binary 0-59.
- s1, s2, m1, m2, h1, h2  out  4 each  BCD digits; 1 = units, 2 = tens.
- pm  out  1  12-hour mode only: 1 = PM; constant 0 when MODE_12H=0.
- tick_1hz  out  1  one-cycle pulse each time the seconds value advances.
- alm_hit  out  1  one-cycle alarm pulse.

Function
REQ-003 The prescaler SHALL count 0..CLK_HZ-1 while run=1 and hold its value while run=0; reaching terminal count SHALL produce a tick and wrap to 0.
REQ-004 Each tick SHALL advance seconds 59->00 with carry to minutes, minutes 59->00 with carry to hours, and hours 23->00; tick_1hz SHALL be asserted in the same cycle the digits update.
REQ-005 Time SHALL be held internally as BCD digits; no binary-to-BCD divider is permitted.
REQ-006 Each button SHALL pass through a repeat FSM with states IDLE, DELAY and REPEAT.
- IDLE -> DELAY on a rising edge; that transition emits one increment pulse.
- DELAY -> REPEAT after REPEAT_DLY held cycles; that transition emits a pulse.
- In REPEAT, one pulse is emitted every REPEAT_PER held cycles.
- Any state -> IDLE when the button is released.
REQ-007 An hour pulse SHALL increment hours modulo 24 with no effect on minutes or seconds.
REQ-008 A minute pulse SHALL increment minutes modulo 60 with no carry to hours, and SHALL clear seconds and the prescaler to 0.
REQ-009 When a set pulse and a tick coincide, the set pulse SHALL be applied and the prescaler SHALL hold at terminal count, so the tick occurs on the next cycle; no second is lost.
REQ-010 When hr_btn and min_btn pulses coincide, both SHALL be applied in the same cycle.
REQ-011 clr=1 SHALL force 00:00:00, clear the prescaler and return both FSMs to IDLE; clr SHALL have priority over ticks and set pulses.
REQ-012 Set buttons SHALL operate regardless of run.
REQ-013 With MODE_12H=1, internal hour 0 SHALL display as 12 with pm=0, hours 1-11 as-is with pm=0, 12 as 12 with pm=1, and 13-23 as hour-12 with pm=1; the display mapping SHALL be registered and add one cycle of latency relative to tick_1hz.
REQ-014 All outputs SHALL be registered.

Reset
REQ-015 While reset_n=0, all registers SHALL clear asynchronously: the time reads 00:00:00, all digits are 0 (h2:h1 = 1:2 when MODE_12H=1), pm=0, tick_1hz=0, alm_hit=0, and both FSMs are in IDLE.
REQ-016 Reset release SHALL be synchronised internally; the first tick SHALL occur CLK_HZ cycles after the first run=1 cycle.
REQ-017 Reset asserted mid-repeat SHALL emit no pulse on release.

Configuration
REQ-018 With TIMEKEEPER_ALARM_EN defined, alm_hit SHALL pulse for one cycle when a tick makes the time equal alm_hr:alm_min:00; manual set SHALL never trigger it.
REQ-019 Without TIMEKEEPER_ALARM_EN, alm_hit SHALL be tied 0, alm_hr and alm_min SHALL be ignored, and the compare logic SHALL be absent; the port list SHALL be unchanged.

Structure
REQ-020 Package timekeeper_pkg SHALL hold the BCD digit typedef, the repeat-FSM state enum, and the constants 59, 23 and 12.
REQ-021 The repeat FSM SHALL be sub-module btn_repeat, with REPEAT_DLY and REPEAT_PER as parameters, instantiated twice.

Verification (CLK_HZ=10, REPEAT_DLY=30, REPEAT_PER=5)
REQ-022 Verification SHALL cover the following directed scenarios:
- Preload 23:59:58, run=1, 20 cycles -> display 00:00:00 and two tick_1hz pulses.
- hr_btn held 45 cycles from 00:00 -> hours read 04: edge, DELAY exit, +5, +10 cycles.
- min_btn rising edge in the same cycle as a tick at 00:05:37 -> 00:06:00; the deferred tick gives 00:06:01 one cycle later.
- MODE_12H=1, preload 11:59:59 with run=1 -> display 12:00:00 with pm=1 one cycle after tick_1hz.
- Alarm enabled, alm 00:01, run from 00:00:50 -> alm_hit pulses once at 00:01:00; setting minutes to 01 manually -> no pulse.
- reset_n low during REPEAT, then released -> all outputs 0 and no increment.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the BCD timekeeper: digit type, repeat-FSM
// states, wrap limits and small BCD helpers used by the datapath.
package timekeeper_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    localparam int unsigned MAX_SEC_MIN = 59;
    localparam int unsigned MAX_HOUR    = 23;
    localparam int unsigned HALF_DAY    = 12;

    // Two BCD digits to a 7-bit binary value using shifts and adds only.
    function automatic logic [6:0] to_bin7(input bcd_t tens, input bcd_t units);
        return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
    endfunction

    // Increment a two-digit BCD value, wrapping to 00 after max.
    function automatic logic [7:0] bcd_inc(input bcd_t tens, input bcd_t units,
                                           input int unsigned max);
        if (to_bin7(tens, units) == 7'(max))
            return 8'h00;
        else if (units == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, units + 4'd1};
    endfunction

endpackage

// File: rtl/timekeeper_ctrl_btn_repeat.sv
// Press-and-hold auto-repeat for one debounced set button.
// A pulse is decoded from the current state and button level so that it is
// visible in the same cycle as the rising edge that causes it.
module btn_repeat
    import timekeeper_pkg::*;
#(
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

    rpt_state_t    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          prev_reg;

    // Pulse decode: rising edge in IDLE, or the held-cycle counter expiring.
    always_comb begin
        pulse = 1'b0;
        if (!clr && btn) begin
            case (state_reg)
                ST_IDLE:   pulse = !prev_reg;
                ST_DELAY:  pulse = (cnt_reg == DLY_LAST);
                ST_REPEAT: pulse = (cnt_reg == PER_LAST);
                default:   pulse = 1'b0;
            endcase
        end
    end

    // Repeat FSM; prev resets high so a button still held across reset is
    // not mistaken for a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            prev_reg  <= 1'b1;
        end else begin
            prev_reg <= btn;
            if (clr || !btn) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!prev_reg) begin
                            state_reg <= ST_DELAY;
                            cnt_reg   <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (cnt_reg == DLY_LAST) begin
                            state_reg <= ST_REPEAT;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (cnt_reg == PER_LAST)
                            cnt_reg <= '0;
                        else
                            cnt_reg <= cnt_reg + CW'(1);
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/timekeeper_ctrl.sv
// BCD time-of-day counter with prescaler, hour/minute set buttons with
// auto-repeat, optional 12-hour display mapping and optional alarm.
// Optional feature macro: TIMEKEEPER_ALARM_EN (alarm compare and alm_hit pulse).
module timekeeper_ctrl
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int REPEAT_DLY = CLK_HZ / 2,
    parameter int REPEAT_PER = CLK_HZ / 10,
    parameter int MODE_12H   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       clr,
    input  logic       hr_btn,
    input  logic       min_btn,
    input  logic [4:0] alm_hr,
    input  logic [5:0] alm_min,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [3:0] m1,
    output logic [3:0] m2,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic       pm,
    output logic       tick_1hz,
    output logic       alm_hit
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

    // Reset: asserts immediately, releases two clocks after reset_n rises.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    // Reset release synchroniser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rst_sync_reg <= 2'b00;
        else
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_int_n = rst_sync_reg[1];

    // Set buttons: bit 0 = hours, bit 1 = minutes.
    logic [1:0] btn_vec;
    logic [1:0] pulse_vec;
    logic       hr_pulse, min_pulse, set_any;

    assign btn_vec = {min_btn, hr_btn};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_btn
        btn_repeat #(
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_rpt (
            .clk   (clk),
            .rst_n (rst_int_n),
            .clr   (clr),
            .btn   (btn_vec[gi]),
            .pulse (pulse_vec[gi])
        );
    end

    assign hr_pulse  = pulse_vec[0];
    assign min_pulse = pulse_vec[1];
    assign set_any   = hr_pulse | min_pulse;

    // Time state, two BCD digits per field: {tens, units}.
    logic [PW-1:0] pre_reg;
    logic [7:0]    sec_reg, min_reg, hr_reg;
    logic          tick_reg;
    logic          tick_now;

    assign tick_now = run && (pre_reg == PRE_TC);

    logic [7:0] sec_inc, min_inc, hr_inc;
    logic [7:0] adv_sec, adv_min, adv_hr;
    logic       sec_wrap, min_wrap;

    // Next time for a one-second advance, plus the per-field increments reused by set.
    always_comb begin
        sec_inc  = bcd_inc(sec_reg[7:4], sec_reg[3:0], MAX_SEC_MIN);
        min_inc  = bcd_inc(min_reg[7:4], min_reg[3:0], MAX_SEC_MIN);
        hr_inc   = bcd_inc(hr_reg[7:4],  hr_reg[3:0],  MAX_HOUR);
        sec_wrap = (to_bin7(sec_reg[7:4], sec_reg[3:0]) == 7'(MAX_SEC_MIN));
        min_wrap = (to_bin7(min_reg[7:4], min_reg[3:0]) == 7'(MAX_SEC_MIN));
        adv_sec  = sec_inc;
        adv_min  = sec_wrap ? min_inc : min_reg;
        adv_hr   = (sec_wrap && min_wrap) ? hr_inc : hr_reg;
    end

    // Timekeeping: clr wins, then a tick unless a set pulse defers it by
    // holding the prescaler at terminal count for one more cycle.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pre_reg  <= '0;
            sec_reg  <= 8'h00;
            min_reg  <= 8'h00;
            hr_reg   <= 8'h00;
            tick_reg <= 1'b0;
        end else if (clr) begin
            pre_reg  <= '0;
            sec_reg  <= 8'h00;
            min_reg  <= 8'h00;
            hr_reg   <= 8'h00;
            tick_reg <= 1'b0;
        end else if (tick_now && !set_any) begin
            pre_reg  <= '0;
            sec_reg  <= adv_sec;
            min_reg  <= adv_min;
            hr_reg   <= adv_hr;
            tick_reg <= 1'b1;
        end else begin
            tick_reg <= 1'b0;
            if (hr_pulse)
                hr_reg <= hr_inc;
            if (min_pulse) begin
                min_reg <= min_inc;
                sec_reg <= 8'h00;
            end
            if (!tick_now) begin
                if (min_pulse)
                    pre_reg <= '0;
                else if (run)
                    pre_reg <= pre_reg + PW'(1);
            end
        end
    end

    assign tick_1hz = tick_reg;

`ifdef TIMEKEEPER_ALARM_EN
    logic alm_match;
    logic alm_reg;

    assign alm_match = (to_bin7(adv_hr[7:4], adv_hr[3:0]) == {2'b00, alm_hr}) &&
                       (to_bin7(adv_min[7:4], adv_min[3:0]) == {1'b0, alm_min}) &&
                       (adv_sec == 8'h00);

    // Alarm fires only on a tick that actually advances the time.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)
            alm_reg <= 1'b0;
        else
            alm_reg <= !clr && tick_now && !set_any && alm_match;
    end

    assign alm_hit = alm_reg;
`else
    logic alm_unused;
    assign alm_unused = ^{alm_hr, alm_min};
    assign alm_hit    = 1'b0;
`endif

    if (MODE_12H != 0) begin : g_12h
        logic [6:0] hr_bin;
        logic [7:0] map_hr;
        logic       map_pm;
        logic [7:0] disp_sec_reg, disp_min_reg, disp_hr_reg;
        logic       disp_pm_reg;

        // 24h -> 12h mapping; 13..23 minus 12 done as a BCD borrow subtract.
        always_comb begin
            hr_bin = to_bin7(hr_reg[7:4], hr_reg[3:0]);
            map_hr = hr_reg;
            map_pm = 1'b0;
            if (hr_bin == 7'd0) begin
                map_hr = 8'h12;
            end else if (hr_bin == 7'(HALF_DAY)) begin
                map_pm = 1'b1;
            end else if (hr_bin > 7'(HALF_DAY)) begin
                map_pm = 1'b1;
                if (hr_reg[3:0] >= 4'd2)
                    map_hr = {hr_reg[7:4] - 4'd1, hr_reg[3:0] - 4'd2};
                else
                    map_hr = {hr_reg[7:4] - 4'd2, hr_reg[3:0] + 4'd8};
            end
        end

        // Display register: whole display lags the time state by one cycle.
        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                disp_sec_reg <= 8'h00;
                disp_min_reg <= 8'h00;
                disp_hr_reg  <= 8'h12;
                disp_pm_reg  <= 1'b0;
            end else begin
                disp_sec_reg <= sec_reg;
                disp_min_reg <= min_reg;
                disp_hr_reg  <= map_hr;
                disp_pm_reg  <= map_pm;
            end
        end

        assign s1 = disp_sec_reg[3:0];
        assign s2 = disp_sec_reg[7:4];
        assign m1 = disp_min_reg[3:0];
        assign m2 = disp_min_reg[7:4];
        assign h1 = disp_hr_reg[3:0];
        assign h2 = disp_hr_reg[7:4];
        assign pm = disp_pm_reg;
    end else begin : g_24h
        assign s1 = sec_reg[3:0];
        assign s2 = sec_reg[7:4];
        assign m1 = min_reg[3:0];
        assign m2 = min_reg[7:4];
        assign h1 = hr_reg[3:0];
        assign h2 = hr_reg[7:4];
        assign pm = 1'b0;
    end

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Directed bench for timekeeper_ctrl with CLK_HZ=10, REPEAT_DLY=30, REPEAT_PER=5.
// Two instances share stimulus: dut (24-hour) and dut12 (12-hour display).
module tb_timekeeper_ctrl;

    logic       clk;
    logic       reset_n;
    logic       run, clr, hr_btn, min_btn;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;

    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic       pm, tick_1hz, alm_hit;
    logic [3:0] s1_12, s2_12, m1_12, m2_12, h1_12, h2_12;
    logic       pm_12, tick_12, alm_12;

    logic [23:0] disp, disp12;
    assign disp   = {h2, h1, m2, m1, s2, s1};
    assign disp12 = {h2_12, h1_12, m2_12, m1_12, s2_12, s1_12};

    int checks = 0;
    int errors = 0;

`ifdef TIMEKEEPER_ALARM_EN
    localparam int EXP_ALM_HITS = 1;
`else
    localparam int EXP_ALM_HITS = 0;
`endif

    timekeeper_ctrl #(.CLK_HZ(10), .REPEAT_DLY(30), .REPEAT_PER(5), .MODE_12H(0)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .clr(clr),
        .hr_btn(hr_btn), .min_btn(min_btn), .alm_hr(alm_hr), .alm_min(alm_min),
        .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
        .pm(pm), .tick_1hz(tick_1hz), .alm_hit(alm_hit)
    );

    timekeeper_ctrl #(.CLK_HZ(10), .REPEAT_DLY(30), .REPEAT_PER(5), .MODE_12H(1)) dut12 (
        .clk(clk), .reset_n(reset_n), .run(run), .clr(clr),
        .hr_btn(hr_btn), .min_btn(min_btn), .alm_hr(alm_hr), .alm_min(alm_min),
        .s1(s1_12), .s2(s2_12), .m1(m1_12), .m2(m2_12), .h1(h1_12), .h2(h2_12),
        .pm(pm_12), .tick_1hz(tick_12), .alm_hit(alm_12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clear, tap buttons to set hh:mm, then run exactly ss seconds.
    task automatic preload(input int hh, input int mm, input int ss);
        clr = 1'b1; step(1); clr = 1'b0;
        repeat (hh) begin hr_btn = 1'b1; step(1); hr_btn = 1'b0; step(1); end
        repeat (mm) begin min_btn = 1'b1; step(1); min_btn = 1'b0; step(1); end
        run = 1'b1; step(10 * ss); run = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        checks++;
        if (disp !== 24'h000000 || pm !== 1'b0 || tick_1hz !== 1'b0 || alm_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_24h got disp=%h pm=%b tick=%b alm=%b exp 000000 0 0 0", disp, pm, tick_1hz, alm_hit);
        end
        checks++;
        if (disp12 !== 24'h120000 || pm_12 !== 1'b0) begin
            errors++;
            $display("FAIL reset_12h got disp=%h pm=%b exp 120000 0", disp12, pm_12);
        end
        reset_n = 1'b1;
        step(4);
        $display("reset: disp=%h disp12=%h", disp, disp12);
    endtask

    task automatic test_first_tick();
        int n;
        int extra;
        n = 0;
        run = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (tick_1hz === 1'b1) begin n = i; break; end
        end
        run = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL first_tick got cycle %0d exp 10", n);
        end
        checks++;
        if (disp !== 24'h000001) begin
            errors++;
            $display("FAIL first_tick_time got %h exp 000001", disp);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick_1hz === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || disp !== 24'h000001) begin
            errors++;
            $display("FAIL run_hold got ticks=%0d disp=%h exp 0 000001", extra, disp);
        end
        $display("first_tick: cycle=%0d disp=%h", n, disp);
    endtask

    task automatic test_rollover();
        int ticks;
        preload(23, 59, 58);
        checks++;
        if (disp !== 24'h235958) begin
            errors++;
            $display("FAIL preload_235958 got %h exp 235958", disp);
        end
        checks++;
        if (disp12 !== 24'h115958 || pm_12 !== 1'b1) begin
            errors++;
            $display("FAIL map_23h got %h pm=%b exp 115958 1", disp12, pm_12);
        end
        ticks = 0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick_1hz === 1'b1) ticks++;
        end
        run = 1'b0;
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL rollover_ticks got %0d exp 2", ticks);
        end
        checks++;
        if (disp !== 24'h000000) begin
            errors++;
            $display("FAIL rollover_time got %h exp 000000", disp);
        end
        step(1);
        checks++;
        if (disp12 !== 24'h120000 || pm_12 !== 1'b0) begin
            errors++;
            $display("FAIL map_midnight got %h pm=%b exp 120000 0", disp12, pm_12);
        end
        $display("rollover: ticks=%0d disp=%h disp12=%h", ticks, disp, disp12);
    endtask

    task automatic test_hr_hold();
        clr = 1'b1; step(1); clr = 1'b0;
        hr_btn = 1'b1;
        step(45);
        hr_btn = 1'b0;
        step(3);
        checks++;
        if (disp !== 24'h040000) begin
            errors++;
            $display("FAIL hr_hold got %h exp 040000", disp);
        end
        $display("hr_hold: disp=%h", disp);
    endtask

    task automatic test_set_tick_collision();
        preload(0, 5, 37);
        checks++;
        if (disp !== 24'h000537) begin
            errors++;
            $display("FAIL preload_000537 got %h exp 000537", disp);
        end
        run = 1'b1;
        step(9);
        min_btn = 1'b1;
        step(1);
        checks++;
        if (disp !== 24'h000600 || tick_1hz !== 1'b0) begin
            errors++;
            $display("FAIL collide_set got %h tick=%b exp 000600 0", disp, tick_1hz);
        end
        min_btn = 1'b0;
        step(1);
        checks++;
        if (disp !== 24'h000601 || tick_1hz !== 1'b1) begin
            errors++;
            $display("FAIL collide_deferred got %h tick=%b exp 000601 1", disp, tick_1hz);
        end
        run = 1'b0;
        step(2);
        $display("collision: disp=%h", disp);
    endtask

    task automatic test_both_buttons();
        clr = 1'b1; step(1); clr = 1'b0;
        hr_btn = 1'b1; min_btn = 1'b1;
        step(1);
        hr_btn = 1'b0; min_btn = 1'b0;
        step(2);
        checks++;
        if (disp !== 24'h010100) begin
            errors++;
            $display("FAIL both_buttons got %h exp 010100", disp);
        end
        hr_btn = 1'b1; clr = 1'b1;
        step(1);
        hr_btn = 1'b0; clr = 1'b0;
        step(2);
        checks++;
        if (disp !== 24'h000000) begin
            errors++;
            $display("FAIL clr_priority got %h exp 000000", disp);
        end
        $display("both_buttons/clr: disp=%h", disp);
    endtask

    task automatic test_12h();
        int found;
        preload(11, 59, 59);
        checks++;
        if (disp12 !== 24'h115959 || pm_12 !== 1'b0) begin
            errors++;
            $display("FAIL preload_115959 got %h pm=%b exp 115959 0", disp12, pm_12);
        end
        found = 0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick_12 === 1'b1) begin found = 1; break; end
        end
        run = 1'b0;
        checks++;
        if (found != 1 || disp12 !== 24'h115959) begin
            errors++;
            $display("FAIL tick12_latency got found=%0d disp=%h exp 1 115959", found, disp12);
        end
        step(1);
        checks++;
        if (disp12 !== 24'h120000 || pm_12 !== 1'b1) begin
            errors++;
            $display("FAIL noon_12h got %h pm=%b exp 120000 1", disp12, pm_12);
        end
        checks++;
        if (disp !== 24'h120000 || pm !== 1'b0) begin
            errors++;
            $display("FAIL noon_24h got %h pm=%b exp 120000 0", disp, pm);
        end
        $display("mode_12h: disp12=%h pm=%b", disp12, pm_12);
    endtask

    task automatic test_alarm();
        int hits;
        int manual_hits;
        alm_hr = 5'd0; alm_min = 6'd1;
        preload(0, 0, 50);
        hits = 0;
        run = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step(1);
            if (alm_hit === 1'b1) begin
                hits++;
                checks++;
                if (disp !== 24'h000100) begin
                    errors++;
                    $display("FAIL alarm_time got %h exp 000100", disp);
                end
            end
        end
        run = 1'b0;
        checks++;
        if (hits != EXP_ALM_HITS) begin
            errors++;
            $display("FAIL alarm_count got %0d exp %0d", hits, EXP_ALM_HITS);
        end
        clr = 1'b1; step(1); clr = 1'b0;
        manual_hits = 0;
        min_btn = 1'b1; step(1);
        if (alm_hit === 1'b1) manual_hits++;
        min_btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (alm_hit === 1'b1) manual_hits++;
        end
        checks++;
        if (manual_hits != 0 || disp !== 24'h000100) begin
            errors++;
            $display("FAIL alarm_manual got hits=%0d disp=%h exp 0 000100", manual_hits, disp);
        end
        $display("alarm: hits=%0d manual_hits=%0d", hits, manual_hits);
    endtask

    task automatic test_reset_mid_repeat();
        clr = 1'b1; step(1); clr = 1'b0;
        hr_btn = 1'b1;
        step(40);
        checks++;
        if (disp !== 24'h030000) begin
            errors++;
            $display("FAIL repeat_before_reset got %h exp 030000", disp);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (disp !== 24'h000000 || pm !== 1'b0 || tick_1hz !== 1'b0 || alm_hit !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got disp=%h pm=%b tick=%b alm=%b exp 000000 0 0 0", disp, pm, tick_1hz, alm_hit);
        end
        checks++;
        if (disp12 !== 24'h120000 || pm_12 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_12h got %h pm=%b exp 120000 0", disp12, pm_12);
        end
        step(3);
        reset_n = 1'b1;
        step(10);
        checks++;
        if (disp !== 24'h000000) begin
            errors++;
            $display("FAIL held_after_reset got %h exp 000000", disp);
        end
        hr_btn = 1'b0;
        step(3);
        checks++;
        if (disp !== 24'h000000 || tick_1hz !== 1'b0 || alm_hit !== 1'b0) begin
            errors++;
            $display("FAIL release_after_reset got %h tick=%b alm=%b exp 000000 0 0", disp, tick_1hz, alm_hit);
        end
        $display("reset_mid_repeat: disp=%h", disp);
    endtask

    initial begin
        reset_n = 1'b0;
        run = 1'b0; clr = 1'b0; hr_btn = 1'b0; min_btn = 1'b0;
        alm_hr = 5'd0; alm_min = 6'd1;
        test_reset();
        test_first_tick();
        test_rollover();
        test_hr_hold();
        test_set_tick_collision();
        test_both_buttons();
        test_12h();
        test_alarm();
        test_reset_mid_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
